bcd_mod_counter: RTL and testbench
==================================

BCD_MOD_COUNTER -- requirements
Module: bcd_mod_counter

Interface
REQ-001 Parameter DIGITS, default 2, number of BCD digits (legal 1..4).
REQ-002 Parameter MAX_VAL, default 59, decimal terminal value; SHALL satisfy MIN_VAL < MAX_VAL < 10**DIGITS.
REQ-003 Parameter MIN_VAL, default 0, decimal wrap/reset value (e.g. 1 for a 12-hour field).
REQ-004 clk  input  1  rising-edge clock, sole clock domain.
REQ-005 reset_n  input  1  synchronous, active-low reset.
REQ-006 enable  input  1  advance count by one step this cycle.
REQ-007 up  input  1  direction: 1 = increment, 0 = decrement.
REQ-008 load  input  1  synchronous load request.
REQ-009 load_val  input  4*DIGITS  packed BCD load value, digit 0 in bits [3:0].
REQ-010 count  output  4*DIGITS  packed BCD count, digit 0 in bits [3:0], registered.
REQ-011 tc  output  1  combinational terminal-count: enable & (up ? count==MAX_VAL : count==MIN_VAL).
REQ-012 load_err  output  1  registered one-cycle pulse on a rejected load.

Function
REQ-013 Priority per cycle SHALL be reset_n low > load > enable; enable is ignored in a load cycle.
REQ-014 enable=1, up=1, count<MAX_VAL: count SHALL become count+1 in BCD on the next edge (digit 9 -> 0 with carry into the next digit).
REQ-015 enable=1, up=1, count==MAX_VAL: count SHALL become MIN_VAL on the next edge.
REQ-016 enable=1, up=0, count>MIN_VAL: count SHALL become count-1 in BCD (digit 0 -> 9 with borrow).
REQ-017 enable=1, up=0, count==MIN_VAL: count SHALL become MAX_VAL on the next edge.
REQ-018 enable=0 and load=0: count SHALL hold.
REQ-019 Latency: one clock from enable/load sample to updated count.
REQ-020 load accepted only if every load_val digit <= 9 and MIN_VAL <= value <= MAX_VAL; count SHALL take load_val next edge, load_err=0.
REQ-021 Rejected load: count SHALL hold, load_err SHALL pulse high for exactly one cycle on the next edge.
REQ-022 load_err SHALL be 0 in every cycle not following a rejected load.
REQ-023 tc SHALL depend only on current count, enable, up (no registered delay) so tc of one instance can drive enable of the next in a cascade within one cycle.
REQ-024 Direction change (up toggled) SHALL take effect in the same cycle it is sampled; no pipeline of direction.
REQ-025 count SHALL never hold a non-BCD digit or a value outside [MIN_VAL, MAX_VAL].

Reset
REQ-026 reset_n low at a rising edge SHALL set count = MIN_VAL (BCD) and load_err = 0, regardless of load/enable.
REQ-027 reset_n asserted mid-count or coincident with load or wrap SHALL win; first post-reset step SHALL start from MIN_VAL.
REQ-028 No asynchronous path from reset_n to any flop.

Structure
REQ-029 Shared package clock_pkg SHALL hold BCD digit type (4-bit), BCD_MAX_DIGIT = 9, and a function converting a decimal integer to packed BCD used for MAX_VAL/MIN_VAL constants.
REQ-030 One sub-module bcd_digit SHALL implement a single digit: inc/dec with carry/borrow in, carry/borrow out, load; bcd_mod_counter instantiates DIGITS copies plus terminal compare logic.
REQ-031 Modulo compare SHALL be done on packed BCD constants; no binary-to-BCD conversion in the datapath.
REQ-032 Elaboration SHALL fail (assertion) for illegal DIGITS, MIN_VAL, MAX_VAL.

Verification
REQ-033 Default params, reset then enable=1 up=1 for 60 cycles -> count 00..59 then 00; tc high only while count==59.
REQ-034 DIGITS=2 MIN_VAL=1 MAX_VAL=12, up=0 from 01 -> next count 12, then 11; tc high at 01.
REQ-035 load=1 load_val=0x47 with enable=1 -> count 47 next edge, no increment; load_val=0x6A or 0x75 (MAX 59) -> count holds, load_err one-cycle pulse.
REQ-036 count=0x39, assert reset_n=0 with load=1 load_val=0x10 -> count 00, load_err 0.
REQ-037 Cascade 2 instances (59 / MAX 23), second enable = first tc; from 23:59 one step -> 00:00, both tc high in that cycle.
REQ-038 DIGITS=3 MAX_VAL=999 up=0 from 100 -> 099 (borrow across two digits); toggle up next cycle -> 100.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared BCD types, constants and helpers for the clock/counter blocks.
package clock_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX_DIGIT = 4'd9;
    localparam int         BCD_MAX_DIGITS = 4;

    // Decimal integer to packed BCD (up to four digits, digit 0 in [3:0]).
    // Only used to build elaboration-time constants.
    function automatic logic [4*BCD_MAX_DIGITS-1:0] to_bcd(input int value);
        logic [4*BCD_MAX_DIGITS-1:0] bcd;
        int v;
        bcd = '0;
        v   = value;
        for (int i = 0; i < BCD_MAX_DIGITS; i++) begin
            bcd[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return bcd;
    endfunction

    // 10**n for small non-negative n.
    function automatic int pow10(input int n);
        int p;
        p = 1;
        for (int i = 0; i < n; i++) begin
            p = p * 10;
        end
        return p;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit: load, or step up/down with carry/borrow in and out.
module bcd_digit
    import clock_pkg::*;
#(
    parameter bcd_digit_t RST_VAL = 4'd0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_up,
    input  logic       i_step,
    input  logic       i_load,
    input  bcd_digit_t i_load_val,
    output bcd_digit_t o_digit,
    output logic       o_carry
);

    bcd_digit_t r_digit;
    bcd_digit_t w_digit_next;

    // Next digit: load wins over stepping; stepping wraps 9<->0.
    always_comb begin
        w_digit_next = r_digit;
        if (i_load) begin
            w_digit_next = i_load_val;
        end else if (i_step) begin
            if (i_up) begin
                w_digit_next = (r_digit == BCD_MAX_DIGIT) ? 4'd0 : r_digit + 4'd1;
            end else begin
                w_digit_next = (r_digit == 4'd0) ? BCD_MAX_DIGIT : r_digit - 4'd1;
            end
        end
    end

    // Digit register with synchronous active-low reset to this digit of MIN_VAL.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_digit <= RST_VAL;
        end else begin
            r_digit <= w_digit_next;
        end
    end

    // Carry (up) or borrow (down) ripples when this digit wraps during a step.
    assign o_carry = i_step & (i_up ? (r_digit == BCD_MAX_DIGIT) : (r_digit == 4'd0));
    assign o_digit = r_digit;

endmodule

// File: rtl/bcd_mod_counter.sv
// Modulo BCD up/down counter with wrap between MIN_VAL and MAX_VAL,
// validated synchronous load and a combinational cascade terminal count.
module bcd_mod_counter
    import clock_pkg::*;
#(
    parameter int DIGITS  = 2,
    parameter int MAX_VAL = 59,
    parameter int MIN_VAL = 0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic                up,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    output logic [4*DIGITS-1:0] count,
    output logic                tc,
    output logic                load_err
);

    localparam int W = 4 * DIGITS;

    // Illegal parameterisations stop elaboration.
    if (DIGITS < 1 || DIGITS > BCD_MAX_DIGITS) begin : g_bad_digits
        $error("bcd_mod_counter: DIGITS must be 1..4");
    end
    if (!(MIN_VAL >= 0 && MIN_VAL < MAX_VAL && MAX_VAL < pow10(DIGITS))) begin : g_bad_range
        $error("bcd_mod_counter: need 0 <= MIN_VAL < MAX_VAL < 10**DIGITS");
    end

    localparam logic [4*BCD_MAX_DIGITS-1:0] MAX_BCD_FULL = to_bcd(MAX_VAL);
    localparam logic [4*BCD_MAX_DIGITS-1:0] MIN_BCD_FULL = to_bcd(MIN_VAL);
    localparam logic [W-1:0]                MAX_BCD      = MAX_BCD_FULL[W-1:0];
    localparam logic [W-1:0]                MIN_BCD      = MIN_BCD_FULL[W-1:0];

    logic [W-1:0]    w_count;
    logic [W-1:0]    w_load_word;
    logic [DIGITS:0] w_carry;
    logic            w_at_term;
    logic            w_digits_ok;
    logic            w_load_ok;
    logic            w_do_load;
    logic            r_load_err;

    // Every load digit must be a legal BCD digit.
    always_comb begin
        w_digits_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (load_val[4*i +: 4] > BCD_MAX_DIGIT) begin
                w_digits_ok = 1'b0;
            end
        end
    end

    // With all digits legal, packed BCD orders exactly like the decimal value,
    // so range checks compare directly against the packed BCD limits.
    assign w_load_ok = w_digits_ok && (load_val >= MIN_BCD) && (load_val <= MAX_BCD);

    // Terminal value for the current direction; reaching it means wrap next.
    assign w_at_term = up ? (w_count == MAX_BCD) : (w_count == MIN_BCD);

    // Wrap is a parallel load of the opposite limit; an accepted load uses load_val.
    assign w_do_load   = load ? w_load_ok : (enable & w_at_term);
    assign w_load_word = load ? load_val : (up ? MIN_BCD : MAX_BCD);

    // Ripple step enable: digit 0 steps on a normal count, higher digits on carry.
    assign w_carry[0] = enable & ~load & ~w_at_term;

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        bcd_digit #(
            .RST_VAL (MIN_BCD[4*gi +: 4])
        ) u_digit (
            .clk        (clk),
            .reset_n    (reset_n),
            .i_up       (up),
            .i_step     (w_carry[gi]),
            .i_load     (w_do_load),
            .i_load_val (w_load_word[4*gi +: 4]),
            .o_digit    (w_count[4*gi +: 4]),
            .o_carry    (w_carry[gi+1])
        );
    end

    // A carry out of the top digit would mean stepping past MAX/MIN, which the
    // terminal wrap prevents; flag it if the datapath ever does so.
    a_no_overflow : assert property (@(posedge clk) disable iff (!reset_n) !w_carry[DIGITS]);

    // Rejected-load flag: one-cycle pulse after a load that failed validation.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_load_err <= 1'b0;
        end else begin
            r_load_err <= load & ~w_load_ok;
        end
    end

    assign count    = w_count;
    assign tc       = enable & w_at_term;
    assign load_err = r_load_err;

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Self-checking bench for bcd_mod_counter: directed scenarios plus a
// randomized run against a decimal-integer reference model.
module tb_bcd_mod_counter;

    int checks;
    int errors;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: defaults (00..59)
    logic       a_rst_n, a_en, a_up, a_ld, a_tc, a_err;
    logic [7:0] a_lv, a_cnt;
    // Instance B: 01..12
    logic       b_rst_n, b_en, b_up, b_ld, b_tc, b_err;
    logic [7:0] b_lv, b_cnt;
    // Cascade: low 00..59, high 00..23
    logic       c_rst_n, c_lo_en, c_up, c_ld, c_lo_tc, c_hi_tc, c_lo_err, c_hi_err;
    logic [7:0] c_lo_lv, c_hi_lv, c_lo_cnt, c_hi_cnt;
    // Instance D: 3 digits 000..999
    logic        d_rst_n, d_en, d_up, d_ld, d_tc, d_err;
    logic [11:0] d_lv, d_cnt;

    bcd_mod_counter u_a (
        .clk(clk), .reset_n(a_rst_n), .enable(a_en), .up(a_up), .load(a_ld),
        .load_val(a_lv), .count(a_cnt), .tc(a_tc), .load_err(a_err));

    bcd_mod_counter #(.DIGITS(2), .MAX_VAL(12), .MIN_VAL(1)) u_b (
        .clk(clk), .reset_n(b_rst_n), .enable(b_en), .up(b_up), .load(b_ld),
        .load_val(b_lv), .count(b_cnt), .tc(b_tc), .load_err(b_err));

    bcd_mod_counter u_c_lo (
        .clk(clk), .reset_n(c_rst_n), .enable(c_lo_en), .up(c_up), .load(c_ld),
        .load_val(c_lo_lv), .count(c_lo_cnt), .tc(c_lo_tc), .load_err(c_lo_err));

    bcd_mod_counter #(.DIGITS(2), .MAX_VAL(23), .MIN_VAL(0)) u_c_hi (
        .clk(clk), .reset_n(c_rst_n), .enable(c_lo_tc), .up(c_up), .load(c_ld),
        .load_val(c_hi_lv), .count(c_hi_cnt), .tc(c_hi_tc), .load_err(c_hi_err));

    bcd_mod_counter #(.DIGITS(3), .MAX_VAL(999), .MIN_VAL(0)) u_d (
        .clk(clk), .reset_n(d_rst_n), .enable(d_en), .up(d_up), .load(d_ld),
        .load_val(d_lv), .count(d_cnt), .tc(d_tc), .load_err(d_err));

    // ---------------- reference model helpers (decimal arithmetic) -------------
    function automatic logic [15:0] bcd_of(input int v);
        logic [15:0] b;
        b = '0;
        b[3:0]   = 4'(v % 10);
        b[7:4]   = 4'((v / 10) % 10);
        b[11:8]  = 4'((v / 100) % 10);
        b[15:12] = 4'((v / 1000) % 10);
        return b;
    endfunction

    // Decimal value of packed BCD, or -1 if any digit is not 0..9.
    function automatic int dec_of(input logic [15:0] b, input int nd);
        int v;
        int d;
        v = 0;
        for (int i = nd - 1; i >= 0; i--) begin
            d = int'(b[4*i +: 4]);
            if (d > 9) return -1;
            v = v * 10 + d;
        end
        return v;
    endfunction

    function automatic int step_of(input int v, input bit dir_up, input int mn, input int mx);
        if (dir_up) return (v == mx) ? mn : v + 1;
        return (v == mn) ? mx : v - 1;
    endfunction

    task automatic edge_settle();
        @(posedge clk);
        #1;
    endtask

    // ---------------------------------------------------------------------------
    task automatic test_reset();
        a_rst_n = 1'b0; a_en = 1'b1; a_up = 1'b1; a_ld = 1'b1; a_lv = 8'h6A;
        b_rst_n = 1'b0; b_en = 1'b0; b_up = 1'b1; b_ld = 1'b0; b_lv = 8'h00;
        c_rst_n = 1'b0; c_lo_en = 1'b0; c_up = 1'b1; c_ld = 1'b0; c_lo_lv = 8'h00; c_hi_lv = 8'h00;
        d_rst_n = 1'b0; d_en = 1'b0; d_up = 1'b1; d_ld = 1'b0; d_lv = 12'h000;
        edge_settle();
        edge_settle();
        checks++;
        if (a_cnt !== 8'h00) begin errors++; $display("FAIL reset_a_count got %h want 00", a_cnt); end
        checks++;
        if (a_err !== 1'b0) begin errors++; $display("FAIL reset_a_err got %b want 0", a_err); end
        checks++;
        if (b_cnt !== 8'h01) begin errors++; $display("FAIL reset_b_count got %h want 01", b_cnt); end
        checks++;
        if (d_cnt !== 12'h000) begin errors++; $display("FAIL reset_d_count got %h want 000", d_cnt); end
        $display("reset: a=%h b=%h d=%h", a_cnt, b_cnt, d_cnt);
        a_rst_n = 1'b1; b_rst_n = 1'b1; c_rst_n = 1'b1; d_rst_n = 1'b1;
        a_ld = 1'b0; a_en = 1'b0;
    endtask

    // Default instance counts 00..59 then wraps to 00; tc only at 59.
    task automatic test_up_wrap();
        int m;
        m = 0;
        for (int c = 0; c < 61; c++) begin
            a_en = 1'b1; a_up = 1'b1; a_ld = 1'b0;
            #1;
            checks++;
            if (a_tc !== (m == 59)) begin
                errors++; $display("FAIL up_wrap_tc at %0d got %b want %b", m, a_tc, (m == 59));
            end
            edge_settle();
            m = step_of(m, 1'b1, 0, 59);
            checks++;
            if (a_cnt !== bcd_of(m)[7:0]) begin
                errors++; $display("FAIL up_wrap_count got %h want %0d", a_cnt, m);
            end
            $display("up_wrap: count=%h tc_before=%b", a_cnt, a_tc);
        end
        a_en = 1'b0;
    endtask

    // 01..12 field counting down: 01 -> 12 -> 11, tc at 01.
    task automatic test_down_min_wrap();
        b_en = 1'b1; b_up = 1'b0; b_ld = 1'b0;
        #1;
        checks++;
        if (b_tc !== 1'b1) begin errors++; $display("FAIL min_wrap_tc got %b want 1", b_tc); end
        edge_settle();
        checks++;
        if (b_cnt !== 8'h12) begin errors++; $display("FAIL min_wrap_first got %h want 12", b_cnt); end
        checks++;
        if (b_tc !== 1'b0) begin errors++; $display("FAIL min_wrap_tc_at_12 got %b want 0", b_tc); end
        edge_settle();
        checks++;
        if (b_cnt !== 8'h11) begin errors++; $display("FAIL min_wrap_second got %h want 11", b_cnt); end
        $display("down_min_wrap: count=%h", b_cnt);
        b_en = 1'b0;
    endtask

    task automatic test_load();
        logic [7:0] lv [5];
        int m;
        lv[0] = 8'h47; lv[1] = 8'h6A; lv[2] = 8'h00; lv[3] = 8'h75; lv[4] = 8'h59;
        m = dec_of({8'h00, a_cnt}, 2);
        for (int i = 0; i < 5; i++) begin
            logic exp_err;
            int v;
            a_en = 1'b1; a_up = 1'b1;
            a_ld = (i != 2);
            a_lv = lv[i];
            edge_settle();
            exp_err = 1'b0;
            if (i == 2) begin
                m = step_of(m, 1'b1, 0, 59);
            end else begin
                v = dec_of({8'h00, lv[i]}, 2);
                if (v >= 0 && v <= 59) m = v;
                else exp_err = 1'b1;
            end
            checks++;
            if (a_cnt !== bcd_of(m)[7:0]) begin
                errors++; $display("FAIL load_count[%0d] got %h want %0d", i, a_cnt, m);
            end
            checks++;
            if (a_err !== exp_err) begin
                errors++; $display("FAIL load_err[%0d] got %b want %b", i, a_err, exp_err);
            end
            $display("load: val=%h ld=%b count=%h err=%b", lv[i], a_ld, a_cnt, a_err);
        end
        a_ld = 1'b0; a_en = 1'b0;
    endtask

    // Reset coincident with load/enable wins; first step afterwards starts at MIN.
    task automatic test_reset_priority();
        a_ld = 1'b1; a_lv = 8'h39; a_en = 1'b0;
        edge_settle();
        checks++;
        if (a_cnt !== 8'h39) begin errors++; $display("FAIL rst_pri_preload got %h want 39", a_cnt); end
        a_rst_n = 1'b0; a_ld = 1'b1; a_lv = 8'h10; a_en = 1'b1;
        edge_settle();
        checks++;
        if (a_cnt !== 8'h00) begin errors++; $display("FAIL rst_pri_count got %h want 00", a_cnt); end
        a_lv = 8'h7F;
        edge_settle();
        checks++;
        if (a_err !== 1'b0) begin errors++; $display("FAIL rst_pri_err got %b want 0", a_err); end
        a_rst_n = 1'b1; a_ld = 1'b0; a_en = 1'b1; a_up = 1'b1;
        edge_settle();
        checks++;
        if (a_cnt !== 8'h01) begin errors++; $display("FAIL rst_pri_first_step got %h want 01", a_cnt); end
        $display("reset_priority: count=%h err=%b", a_cnt, a_err);
        a_en = 1'b0;
    endtask

    // 23:59 -> 00:00 in one step with both tc high in that cycle.
    task automatic test_cascade();
        c_ld = 1'b1; c_lo_lv = 8'h59; c_hi_lv = 8'h23; c_lo_en = 1'b0; c_up = 1'b1;
        edge_settle();
        c_ld = 1'b0; c_lo_en = 1'b1;
        #1;
        checks++;
        if (c_lo_tc !== 1'b1 || c_hi_tc !== 1'b1) begin
            errors++; $display("FAIL cascade_tc got %b%b want 11", c_hi_tc, c_lo_tc);
        end
        edge_settle();
        checks++;
        if ({c_hi_cnt, c_lo_cnt} !== 16'h0000) begin
            errors++; $display("FAIL cascade_wrap got %h:%h want 00:00", c_hi_cnt, c_lo_cnt);
        end
        edge_settle();
        checks++;
        if ({c_hi_cnt, c_lo_cnt} !== 16'h0001) begin
            errors++; $display("FAIL cascade_next got %h:%h want 00:01", c_hi_cnt, c_lo_cnt);
        end
        $display("cascade: %h:%h", c_hi_cnt, c_lo_cnt);
        c_lo_en = 1'b0;
    endtask

    // 3-digit borrow across two digits, then immediate direction change.
    task automatic test_borrow();
        d_ld = 1'b1; d_lv = 12'h100; d_en = 1'b0;
        edge_settle();
        checks++;
        if (d_cnt !== 12'h100) begin errors++; $display("FAIL borrow_load got %h want 100", d_cnt); end
        d_ld = 1'b0; d_en = 1'b1; d_up = 1'b0;
        edge_settle();
        checks++;
        if (d_cnt !== 12'h099) begin errors++; $display("FAIL borrow_down got %h want 099", d_cnt); end
        d_up = 1'b1;
        #1;
        checks++;
        if (d_tc !== 1'b0) begin errors++; $display("FAIL borrow_tc got %b want 0", d_tc); end
        edge_settle();
        checks++;
        if (d_cnt !== 12'h100) begin errors++; $display("FAIL borrow_up got %h want 100", d_cnt); end
        $display("borrow: count=%h", d_cnt);
        d_en = 1'b0;
    endtask

    // Random enable/up/load/reset on instances A (0..59) and B (1..12).
    task automatic test_random();
        int ma, mb, v;
        logic ea, eb;
        a_rst_n = 1'b0; b_rst_n = 1'b0; a_ld = 1'b0; b_ld = 1'b0;
        edge_settle();
        ma = 0; mb = 1; ea = 1'b0; eb = 1'b0;
        for (int n = 0; n < 400; n++) begin
            a_rst_n = ($urandom_range(0, 49) != 0);
            a_ld    = ($urandom_range(0, 7) == 0);
            a_lv    = ($urandom_range(0, 1) == 0) ? 8'($urandom) : bcd_of($urandom_range(0, 99))[7:0];
            a_en    = ($urandom_range(0, 3) != 0);
            a_up    = 1'($urandom_range(0, 1));
            b_rst_n = ($urandom_range(0, 49) != 0);
            b_ld    = ($urandom_range(0, 7) == 0);
            b_lv    = ($urandom_range(0, 1) == 0) ? 8'($urandom) : bcd_of($urandom_range(0, 15))[7:0];
            b_en    = ($urandom_range(0, 3) != 0);
            b_up    = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if (a_tc !== (a_en && (a_up ? (ma == 59) : (ma == 0)))) begin
                errors++; $display("FAIL rand_a_tc n=%0d got %b model=%0d", n, a_tc, ma);
            end
            checks++;
            if (b_tc !== (b_en && (b_up ? (mb == 12) : (mb == 1)))) begin
                errors++; $display("FAIL rand_b_tc n=%0d got %b model=%0d", n, b_tc, mb);
            end
            edge_settle();
            if (!a_rst_n) begin ma = 0; ea = 1'b0; end
            else if (a_ld) begin
                v = dec_of({8'h00, a_lv}, 2);
                ea = !(v >= 0 && v <= 59);
                if (!ea) ma = v;
            end else begin
                ea = 1'b0;
                if (a_en) ma = step_of(ma, a_up, 0, 59);
            end
            if (!b_rst_n) begin mb = 1; eb = 1'b0; end
            else if (b_ld) begin
                v = dec_of({8'h00, b_lv}, 2);
                eb = !(v >= 1 && v <= 12);
                if (!eb) mb = v;
            end else begin
                eb = 1'b0;
                if (b_en) mb = step_of(mb, b_up, 1, 12);
            end
            checks++;
            if (a_cnt !== bcd_of(ma)[7:0] || a_err !== ea) begin
                errors++; $display("FAIL rand_a n=%0d got %h/%b want %0d/%b", n, a_cnt, a_err, ma, ea);
            end
            checks++;
            if (b_cnt !== bcd_of(mb)[7:0] || b_err !== eb) begin
                errors++; $display("FAIL rand_b n=%0d got %h/%b want %0d/%b", n, b_cnt, b_err, mb, eb);
            end
            $display("rand n=%0d a=%h err=%b b=%h err=%b", n, a_cnt, a_err, b_cnt, b_err);
        end
        a_rst_n = 1'b1; b_rst_n = 1'b1; a_ld = 1'b0; b_ld = 1'b0; a_en = 1'b0; b_en = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        #1;
        test_reset();
        test_up_wrap();
        test_down_min_wrap();
        test_load();
        test_reset_priority();
        test_cascade();
        test_borrow();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
